// File: rtl/fuzzy_rule_sequencer.sv
// fuzzy_rule_sequencer: walks the 3x3 fuzzy rule base once per start and drives the rule unit's selects and strobes. FUZZY_SEQ_PROG_TABLE_EN adds a writable rule table.
module fuzzy_rule_sequencer #(
    parameter logic [17:0] RULE_TABLE = 18'h29910,
    parameter int          N_RULES    = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef FUZZY_SEQ_PROG_TABLE_EN
    input  logic       tbl_we,
    input  logic [3:0] tbl_addr,
    input  logic [1:0] tbl_data,
`endif
    output logic [1:0] sel_1,
    output logic [1:0] sel_2,
    output logic [3:0] Pos_men,
    output logic [1:0] Mux_8Canais,
    output logic       clr_saida,
    output logic [3:0] rule_idx,
    output logic       busy,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;
    localparam logic [3:0] LAST = 4'(N_RULES - 1);
    state_t     state, nstate;
    logic [3:0] k, nk;
    logic [1:0] c;
    logic       run;
    logic [17:0] tbl;
`ifdef FUZZY_SEQ_PROG_TABLE_EN
    // table edits land only while no pass is using the table
    always_ff @(posedge clk) begin
        if (rst) tbl <= RULE_TABLE;
        else if (tbl_we && tbl_addr <= 4'd8 && (state == IDLE || state == DONE)) tbl[{tbl_addr, 1'b0} +: 2] <= tbl_data;
    end
`else
    assign tbl = RULE_TABLE;
`endif
    // next state and rule counter
    always_comb begin
        nstate = state;
        nk = k;
        case (state)
            IDLE:  nstate = start ? CLEAR : IDLE;
            CLEAR: begin
                nstate = RUN;
                nk = 4'd0;
            end
            RUN: begin
                nstate = (k == LAST) ? DONE : RUN;
                nk = (k == LAST) ? 4'd0 : k + 4'd1;
            end
            default: nstate = IDLE;
        endcase
        run = (nstate == RUN);
        c = tbl[{nk, 1'b0} +: 2];
    end
    // outputs are flops decoded from the upcoming state so they line up with it
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            k           <= 4'd0;
            sel_1       <= 2'd0;
            sel_2       <= 2'd0;
            Pos_men     <= 4'd0;
            Mux_8Canais <= 2'd0;
            clr_saida   <= 1'b0;
            rule_idx    <= 4'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= nstate;
            k           <= nk;
            sel_1       <= run ? 2'(nk % 4'd3) : 2'd0;
            sel_2       <= run ? 2'(nk / 4'd3) : 2'd0;
            Pos_men     <= (run && c != 2'd3) ? 4'b0001 << c : 4'd0;
            Mux_8Canais <= run ? c : 2'd0;
            clr_saida   <= nstate == CLEAR;
            rule_idx    <= run ? nk : 4'd0;
            busy        <= nstate == CLEAR || run;
            done        <= nstate == DONE;
        end
    end
endmodule

// File: tb/tb_fuzzy_rule_sequencer.sv
// tb_fuzzy_rule_sequencer: scoreboard bench comparing every cycle of the sequencer against a pass-level reference model.
module tb_fuzzy_rule_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] sel_1, sel_2, Mux_8Canais;
    logic [3:0] Pos_men, rule_idx;
    logic       clr_saida, busy, done;
`ifdef FUZZY_SEQ_PROG_TABLE_EN
    logic       tbl_we = 1'b0;
    logic [3:0] tbl_addr = 4'd0;
    logic [1:0] tbl_data = 2'd0;
`endif

    fuzzy_rule_sequencer dut (
        .clk(clk), .rst(rst), .start(start),
`ifdef FUZZY_SEQ_PROG_TABLE_EN
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
`endif
        .sel_1(sel_1), .sel_2(sel_2), .Pos_men(Pos_men), .Mux_8Canais(Mux_8Canais),
        .clr_saida(clr_saida), .rule_idx(rule_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cnt = 0;
    bit armed = 0;
    int tbl[9];
    int def_tbl[9] = '{0, 0, 1, 0, 1, 2, 1, 2, 2};
    logic [16:0] q[$];
    logic [16:0] act, exp_v;

    // record layout {clr, busy, done, sel_1, sel_2, Pos_men, Mux, rule_idx}
    function automatic logic [16:0] rule_rec(int r);
        int cc = tbl[r];
        logic [3:0] p = (cc < 3) ? 4'(1 << cc) : 4'd0;
        return {1'b0, 1'b1, 1'b0, 2'(r % 3), 2'(r / 3), p, 2'(cc), 4'(r)};
    endfunction

    task automatic step(input bit s, input bit r);
        start = s;
        rst = r;
`ifdef FUZZY_SEQ_PROG_TABLE_EN
        tbl_we = ($urandom_range(0, 3) == 0);
        tbl_addr = 4'($urandom_range(0, 15));
        tbl_data = 2'($urandom_range(0, 3));
`endif
        @(posedge clk);
        if (r) begin
            q.delete();
            cnt = 0;
            foreach (tbl[i]) tbl[i] = def_tbl[i];
        end else begin
`ifdef FUZZY_SEQ_PROG_TABLE_EN
            if (tbl_we && tbl_addr <= 8 && cnt <= 1) tbl[tbl_addr] = int'(tbl_data);
`endif
            if (cnt == 0 && s) begin
                q.push_back(17'b1_1_0_00_00_0000_00_0000);
                for (int i = 0; i < 9; i++) q.push_back(rule_rec(i));
                q.push_back(17'b0_0_1_00_00_0000_00_0000);
                cnt = 11;
            end else if (cnt > 0) cnt--;
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (armed) begin
            act = {clr_saida, busy, done, sel_1, sel_2, Pos_men, Mux_8Canais, rule_idx};
            exp_v = (q.size() != 0) ? q.pop_front() : 17'd0;
            tests++;
            if (act !== exp_v) begin
                fails++;
                $display("FAIL cycle_outputs t=%0t got=%h want=%h", $time, act, exp_v);
            end
        end
    end

    initial begin
        foreach (tbl[i]) tbl[i] = def_tbl[i];
        step(0, 1);
        armed = 1;
        step(0, 1);
        step(0, 0);
        step(0, 0);
        step(1, 0);
        repeat (14) step(0, 0);
        repeat (36) step(1, 0);
        repeat (13) step(0, 0);
        step(1, 0);
        repeat (5) step(0, 0);
        step(0, 1);
        step(0, 0);
        step(1, 0);
        repeat (13) step(0, 0);
        repeat (600) step($urandom_range(0, 3) == 0, $urandom_range(0, 199) == 0);
        repeat (15) step(0, 0);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL leftover_expected got=%0d want=0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fuzzy_rule_sequencer.md
Name: fuzzy_rule_sequencer

Overview:
Control-side counterpart of the type-2 fuzzy rule unit. It walks the 3x3 rule base once per inference and, for each rule, drives:
- the antecedent selects (sel_1, sel_2),
- the consequent register write strobe (Pos_men),
- the max-feedback channel select (Mux_8Canais).

Before the walk it pulses a clear to the rule unit's output registers. It signals completion so the downstream defuzzifier can sample saida_0..2.

Parameters:
RULE_TABLE, 18'h29910, consequent index per rule k (0..8) at bits [2k+1:2k]; code 3 = rule disabled
N_RULES, 9, number of rules walked (fixed 3x3; not to be overridden)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request one inference pass; sampled only in IDLE
sel_1  output  2  input-2 fuzzy set select (FOU_04..06), = k mod 3
sel_2  output  2  input-1 fuzzy set select (FOU_01..03), = k div 3
Pos_men  output  4  one-hot consequent register write strobe; 4'b0000 = no write
Mux_8Canais  output  2  feedback channel select = consequent index of current rule
clr_saida  output  1  one-cycle clear pulse to rule unit output registers (ORed into its rst)
rule_idx  output  4  current rule number k
busy  output  1  high in CLEAR and RUN
done  output  1  one-cycle pulse when pass complete

Behaviour:
- Reset (rst=1 at any edge):
  - state=IDLE, k=0.
  - All outputs 0.
  - No clr_saida pulse is generated by reset itself.
  - Reset mid-pass aborts immediately; the table is reloaded from RULE_TABLE.
- All outputs are registered and are a decode of state/k. No combinational path from start to the outputs.
- States:
  - IDLE: all outputs 0. If start=1, go to CLEAR.
  - CLEAR:
    - 1 cycle; clr_saida=1, busy=1, Pos_men=0, sel_1=sel_2=Mux_8Canais=0.
    - Next state RUN with k=0.
  - RUN:
    - Per cycle: c=table[k]; sel_2=k/3, sel_1=k%3, Mux_8Canais=c, Pos_men=(c<3) ? (4'b0001<<c) : 4'b0000; rule_idx=k; busy=1.
    - k increments each cycle. After k=8, go to DONE.
  - DONE: 1 cycle; done=1, busy=0, Pos_men=0. Then IDLE.
- Rate and latency:
  - One rule per clock. Back-to-back rules hitting the same consequent are legal: the rule unit register updates at the edge and the feedback reads the new value next cycle.
  - With start high at edge t: CLEAR cycle t+1, RUN cycles t+2..t+10, done cycle t+11. Total 11 cycles.
  - A new start can be accepted at the edge ending the DONE cycle + 1, i.e. once back in IDLE.
- Handshake rules:
  - start while busy or in DONE is ignored, not queued.
  - start held high continuously produces back-to-back passes with one IDLE cycle between them.
- Disabled rule (code 3): Pos_men=0 for that cycle, no register write, and k still advances.
- Consequent mapping: index 0..2 maps to Pos_men bit 0..2. Pos_men[3] is never asserted.

Optional Feature:
Macro FUZZY_SEQ_PROG_TABLE_EN.
- Defined:
  - Adds ports tbl_we (in, 1), tbl_addr (in, 4), tbl_data (in, 2).
  - The rule table is an 18-bit register initialised from RULE_TABLE on rst.
  - tbl_we=1 with tbl_addr<=8, in IDLE or DONE, writes entry tbl_addr at the edge.
  - Writes while busy=1, or with tbl_addr>8, are dropped.
  - A write at the same edge start is accepted takes effect for that pass.
- Undefined: no extra ports; the table is the constant RULE_TABLE.

Test Plan:
1. rst=1 two cycles, then start pulse at edge 5 -> clr_saida=1 in cycle 6; rule_idx 0..8 in cycles 7..15; done=1 in cycle 16 only; busy=1 in cycles 6..15.
2. Default table -> Pos_men sequence 0001,0001,0010,0001,0010,0100,0010,0100,0100. Mux_8Canais 0,0,1,0,1,2,1,2,2. sel_2 0,0,0,1,1,1,2,2,2. sel_1 0,1,2,0,1,2,0,1,2.
3. Golden check with the rule unit attached: FOU_01..03=40,200,10 and FOU_04..06=90,150,255 -> after done, saida_0=max(min(40,90),min(40,150),min(200,90))=90; saida_1=150; saida_2=min(200,255)=200.
4. rst asserted during RUN at rule_idx=4 -> next cycle all outputs 0, state IDLE, no done. A later start yields a full 11-cycle pass.
5. start held high for 30 cycles -> done pulses exactly every 12 cycles. start pulses during busy produce no extra pass.
6. With FUZZY_SEQ_PROG_TABLE_EN:
   - Write entry 4 = 3 in IDLE -> rule_idx=4 cycle shows Pos_men=0000 and Mux_8Canais=3.
   - Write attempted while busy -> table unchanged.
